uart_tx_mmio: RTL
=================

# uart_tx_mmio

Memory-mapped UART transmitter on the core's data bus, directly downstream of the core. It decodes the core's `addr`/`din`/`write_en` outputs and returns read data on the core's `dout` input in the same cycle. Written bytes are buffered in a small FIFO and serialized as 8N1 frames on `tx`. The baud divisor is programmable.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_1000: byte address of register 0; the block claims `BASE_ADDR`..`BASE_ADDR+11`.
- `FIFO_DEPTH`, default 8: TX FIFO entries; must be a power of 2, at least 2.
- `DIV_RESET`, default 16'd868: reset value of the DIV register, in clocks per bit.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `addr`  in  32 (`word_t`)  byte address from the core.
- `din`  in  32 (`word_t`)  write data from the core.
- `write_en`  in  1  store strobe from the core; the core holds it for exactly one cycle per store.
- `dout`  out  32 (`word_t`)  read data. It is combinational from `addr` and registered state, and is 0 when `addr` misses, so it can be OR-merged with other slaves.
- `tx`  out  1  serial output, registered; idles high.

## Operation
Registers. Offset = `addr - BASE_ADDR`; `addr[1:0]` is ignored.
- +0 DATA
  - Write: push `din[7:0]` into the FIFO.
  - Read: 0.
- +4 STATUS, read-only except for bit 3.
  - bit0 full; bit1 empty; bit2 busy (FSM not IDLE); bit3 overflow (sticky).
  - bits[15:8] FIFO count; all other bits 0.
  - Any write to STATUS clears overflow.
- +8 DIV
  - Bits[15:0] hold clocks per bit; upper bits read 0.
  - A written value of 0 is stored as 1.

FIFO:
- Circular buffer with `$clog2(FIFO_DEPTH)+1`-bit read and write pointers.
- Full when the pointers differ only in the MSB; empty when they are equal.
- A push when full is dropped and sets overflow, except when a pop occurs in the same cycle, in which case the push is accepted.
- A push and pop in the same cycle leave the count unchanged.
- There is no bypass path: every byte passes through the FIFO.

Transmit FSM:
- IDLE: `tx`=1. If the FIFO is non-empty, pop the byte into the shift register, load the baud counter with DIV-1, and go to START.
- START: `tx`=0 for DIV cycles, then go to DATA with bit index 0.
- DATA: `tx`=shift[0] for DIV cycles, then shift right and increment the index. After index 7 completes, go to STOP (or to PARITY when configured).
- PARITY (configured only): `tx`=XOR of the 8 data bits for DIV cycles, then go to STOP.
- STOP: `tx`=1 for DIV cycles. Then go to IDLE, or go directly to START if the FIFO is non-empty, which gives back-to-back frames with no idle gap.

Baud counter:
- Down-counter that reloads with DIV-1 at each bit boundary.
- A DIV write mid-bit takes effect at the next reload; the current bit keeps its length.

## Timing
- Reset values: `tx`=1, FSM=IDLE, pointers=0, overflow=0, DIV=`DIV_RESET`, shift register=0.
- `dout` has no register stage; it reflects state after the most recent edge.
- Latency:
  - A store to DATA is sampled at edge E0; after E0 the FIFO is non-empty.
  - At E1 the byte is popped and the FSM enters START; `tx` falls after E1.
  - A frame is 10×DIV cycles, or 11×DIV cycles with parity.
- STATUS reads in the cycle after a push show the updated count.
- Asserting `rst` mid-frame forces `tx` high immediately, empties the FIFO, and aborts the frame.
- Stores to unmapped offsets (+12 and above fall outside the decode) and reads of DATA have no side effects.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in. Frames are 8E1 (even parity) and 11 bits long.
- `UART_TX_PARITY_EN` undefined: the PARITY state is absent. Frames are 8N1 and 10 bits long.

## Test plan
- Reset: hold `rst` for 3 cycles, then release → `tx`=1; STATUS reads 32'h0000_0002 (empty); DIV reads 868.
- Write DIV=4, then DATA=8'hA5 → `tx` falls 1 cycle after the store edge. Over 40 cycles the bits are 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; then busy=0.
- With DIV=4, store `FIFO_DEPTH`+2 bytes back-to-back, starting with 8'h00 → after the first pop the FIFO fills.
  - The last store is dropped; overflow=1 and count=8.
  - A STATUS write clears overflow.
  - Exactly 9 frames emit with no idle gap between them.
- While a frame is in progress with DIV=4, write DIV=2 mid-bit → the current bit stays at 4 cycles; subsequent bits are 2 cycles.
- Assert `rst` during DATA bit 3 → `tx`=1 immediately; after release STATUS=32'h0000_0002 and no residual frame is sent.
- Build with `UART_TX_PARITY_EN`, DIV=4, DATA=8'h07 → parity bit=1 and the frame lasts 44 cycles. Without the macro, the same stimulus gives a 40-cycle frame with the stop bit right after bit 7.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/DIV registers, TX FIFO, serializer.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
package uart_tx_pkg;
  typedef logic [31:0] word_t;
endpackage

module uart_tx_mmio
  import uart_tx_pkg::*;
#(
  parameter word_t       BASE_ADDR  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic  clk,
  input  logic  rst,
  input  word_t addr,
  input  word_t din,
  input  logic  write_en,
  output word_t dout,
  output logic  tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // Register decode
  word_t off;
  logic  in_rng, sel_data, sel_stat, sel_div;
  assign off      = addr - BASE_ADDR;
  assign in_rng   = (off[31:4] == '0) && (off[3:2] != 2'd3);
  assign sel_data = in_rng && (off[3:2] == 2'd0);
  assign sel_stat = in_rng && (off[3:2] == 2'd1);
  assign sel_div  = in_rng && (off[3:2] == 2'd2);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q, count;
  logic          full, empty, ovf_q, pop, push, accept;
  logic [15:0]   div_q;
  logic [7:0]    head;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d, tx_q, tx_d, busy;

  assign count  = wptr_q - rptr_q;
  assign empty  = (wptr_q == rptr_q);
  assign full   = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});
  assign head   = mem_q[rptr_q[AW-1:0]];
  assign push   = write_en && sel_data;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign accept = push && (!full || pop);
  assign busy   = (state_q != S_IDLE);
  assign tx     = tx_q;

  logic unused_bits;
  assign unused_bits = ^{off[1:0], din[31:16]};

  logic [7:0] cnt8;
  assign cnt8 = 8'(count);

  always_comb begin
    dout = '0;
    if (sel_stat) dout = {16'h0, cnt8, 4'h0, ovf_q, busy, empty, full};
    else if (sel_div) dout = {16'h0, div_q};
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wptr_q[AW-1:0]] <= din[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      div_q  <= DIV_RESET;
    end else begin
      if (accept) wptr_q <= wptr_q + 1'b1;
      if (pop)    rptr_q <= rptr_q + 1'b1;
      if (write_en && sel_stat)        ovf_q <= 1'b0;
      else if (push && full && !pop)   ovf_q <= 1'b1;
      if (write_en && sel_div) div_q <= (din[15:0] == 16'd0) ? 16'd1 : din[15:0];
    end
  end

  // Serializer: cnt_q counts down the current bit; reload picks up DIV only at bit boundaries.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = ^head;
          cnt_d   = div_q - 16'd1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = div_q - 16'd1;
          idx_d   = 3'd0;
          state_d = S_DATA;
        end else cnt_d = cnt_q - 16'd1;
      end
      S_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = div_q - 16'd1;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (idx_q == 3'd7) state_d = S_PARITY;
`else
          if (idx_q == 3'd7) state_d = S_STOP;
`endif
        end else cnt_d = cnt_q - 16'd1;
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = div_q - 16'd1;
          state_d = S_STOP;
        end else cnt_d = cnt_q - 16'd1;
      end
`endif
      S_STOP: begin
        if (cnt_q == 16'd0) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            par_d   = ^head;
            cnt_d   = div_q - 16'd1;
            state_d = S_START;
          end else state_d = S_IDLE;
        end else cnt_d = cnt_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end
endmodule
